// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial pattern detector: state encodings, pattern width,
// default pattern and the elaboration-time KMP next-state table builder.
package seq_detect_ctrl_pkg;

    localparam int PAT_W = 4;
    localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // Entry {k, b} holds the next state from Sk on input bit b. A completed match falls
    // back to the longest proper border of the pattern, which the same search yields.
    function automatic logic [15:0] build_next_tbl(input logic [PAT_W-1:0] pat);
        logic [15:0] tbl;
        logic        seq [PAT_W];
        int          best;
        int          len;
        bit          ok;
        tbl = '0;
        for (int k = 0; k < PAT_W; k++) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < PAT_W; i++)
                    seq[i] = (i < k) ? pat[PAT_W-1-i] : 1'(b);
                len  = k + 1;
                best = 0;
                for (int j = 1; j < PAT_W; j++) begin
                    if (j <= len) begin
                        ok = 1'b1;
                        for (int m = 0; m < j; m++)
                            if (seq[len-j+m] != pat[PAT_W-1-m]) ok = 1'b0;
                        if (ok) best = j;
                    end
                end
                tbl[(2*k+b)*2 +: 2] = 2'(best);
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/seq_out_gen.sv
// Combinational Mealy output of the detector: a match is the final pattern bit
// arriving on a valid cycle while three bits are already matched.
module seq_out_gen #(
    parameter logic MATCH_BIT = 1'b1
) (
    input  logic q1,
    input  logic q0,
    input  logic x,
    input  logic en,
    output logic z
);

    assign z = en & q1 & q0 & (x == MATCH_BIT);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequencing controller for the overlapping 4-bit pattern detector: state register,
// table-driven next-state logic, saturating match counter and sticky saturation flag.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr,
    output logic             q1,
    output logic             q0,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [15:0] NEXT_TBL = build_next_tbl(PATTERN);

    state_t state;
    state_t state_nxt;
    logic   cnt_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= S0;
        else if (clr) state <= S0;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (en) state_nxt = state_t'(NEXT_TBL[{state, x, 1'b0} +: 2]);
    end

    always_comb begin
        q1      = state[1];
        q0      = state[0];
        cnt_max = &match_cnt;
    end

    seq_out_gen #(
        .MATCH_BIT (PATTERN[0])
    ) u_out_gen (
        .q1 (q1),
        .q0 (q0),
        .x  (x),
        .en (en),
        .z  (z)
    );

    // clr wins over a same-cycle match: z still shows it but nothing is recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q       <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (clr) begin
            z_q       <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            z_q <= z;
            if (z) begin
                if (cnt_max) cnt_sat   <= 1'b1;
                else         match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a history-based model of the detector checked every cycle
// against an 8-bit-counter and a 2-bit-counter instance, plus literal spot checks.
module tb_seq_detect_ctrl;

    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst, en, x, clr;
    logic q1a, q0a, za, zqa, sata;
    logic [7:0] cnta;
    logic q1b, q0b, zb, zqb, satb;
    logic [1:0] cntb;

    int checks = 0;
    int errors = 0;

    // Model: recent received bits (newest at bit 0) since reset/clr.
    logic [7:0] hist;
    int         hlen;
    logic       m_zq, m_sat8, m_sat2;
    int         m_cnt8, m_cnt2;
    bit         cmp_on = 0;
    logic       zs;
    int         base;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PATTERN(PAT), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .q1(q1a), .q0(q0a), .z(za), .z_q(zqa), .match_cnt(cnta), .cnt_sat(sata));

    seq_detect_ctrl #(.PATTERN(PAT), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .q1(q1b), .q0(q0b), .z(zb), .z_q(zqb), .match_cnt(cntb), .cnt_sat(satb));

    // Longest pattern prefix (shorter than the pattern) that ends the history.
    function automatic int model_state();
        int best = 0;
        for (int j = 1; j < 4; j++) begin
            bit ok = (j <= hlen);
            for (int m = 0; m < j; m++)
                if (hist[j-1-m] != PAT[3-m]) ok = 0;
            if (ok) best = j;
        end
        return best;
    endfunction

    function automatic logic model_z();
        return en && (hlen >= 3) && ({hist[2:0], x} == PAT);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = '0; hlen = 0; m_zq = 0;
        m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("state8", {q1a, q0a}, model_state());
            chk("state2", {q1b, q0b}, model_state());
            chk("z8", za, model_z());
            chk("z2", zb, model_z());
            chk("zq8", zqa, m_zq);
            chk("zq2", zqb, m_zq);
            chk("cnt8", cnta, m_cnt8);
            chk("cnt2", cntb, m_cnt2);
            chk("sat8", sata, m_sat8);
            chk("sat2", satb, m_sat2);
        end
    end

    // Drive one cycle starting just after a rising edge; returns z seen mid-cycle.
    task automatic step(input logic e, input logic b, input logic c, output logic zo);
        logic mz;
        en = e; x = b; clr = c;
        #1 zo = za;
        @(posedge clk);
        mz = model_z();
        if (c) model_reset();
        else if (e) begin
            hist = {hist[6:0], b};
            if (hlen < 8) hlen++;
            m_zq = mz;
            if (mz) begin
                if (m_cnt8 == 255) m_sat8 = 1; else m_cnt8++;
                if (m_cnt2 == 3)   m_sat2 = 1; else m_cnt2++;
            end
        end else m_zq = 0;
        #1;
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, zs);
    endtask

    initial begin
        rst = 1; en = 0; x = 0; clr = 0;
        model_reset();
        #2;
        chk("rst_state", {q1a, q0a}, 0);
        chk("rst_cnt", cnta, 0);
        chk("rst_sat", sata, 0);
        chk("rst_zq", zqa, 0);
        @(posedge clk); #1 rst = 0;
        cmp_on = 1;

        // Basic detection with literal state trace
        step(1, 1, 0, zs); chk("t2_s1", {q1a, q0a}, 1);
        step(1, 0, 0, zs); chk("t2_s2", {q1a, q0a}, 2);
        step(1, 1, 0, zs); chk("t2_s3", {q1a, q0a}, 3);
        step(1, 1, 0, zs); chk("t2_z", zs, 1);
        chk("t2_zq", zqa, 1); chk("t2_cnt", cnta, 1); chk("t2_after", {q1a, q0a}, 1);
        step(0, 0, 0, zs); chk("t2_zq_drop", zqa, 0);

        // Asynchronous reset mid-sequence
        step(1, 0, 0, zs); step(1, 1, 0, zs); // now S3 via overlap: 1011 -> S1,0->S2,1->S3
        chk("t1_pre", {q1a, q0a}, 3);
        en = 0; rst = 1; model_reset();
        #1;
        chk("t1_state", {q1a, q0a}, 0);
        chk("t1_cnt", cnta, 0);
        chk("t1_sat", sata, 0);
        @(posedge clk); #1 rst = 0;

        // Overlapping matches
        base = cnta;
        step(1, 1, 0, zs); step(1, 0, 0, zs); step(1, 1, 0, zs); step(1, 1, 0, zs);
        chk("t3_s_after4", {q1a, q0a}, 1);
        feed(16'b011, 3);
        chk("t3_two", cnta - base, 2);
        step(0, 0, 1, zs);
        feed(16'b101011, 6);
        chk("t3_one", cnta, 1);

        // en gating
        step(0, 0, 1, zs);
        step(1, 1, 0, zs); step(1, 0, 0, zs);
        for (int i = 0; i < 3; i++) begin
            step(0, 1'($urandom_range(0, 1)), 0, zs);
            chk("t4_noz", zs, 0);
            chk("t4_hold", {q1a, q0a}, 2);
        end
        step(1, 1, 0, zs); step(1, 1, 0, zs);
        chk("t4_z", zs, 1);
        chk("t4_cnt", cnta, 1);

        // Saturation on the 2-bit counter
        step(0, 0, 1, zs);
        feed(16'b1011, 4);
        for (int i = 0; i < 4; i++) begin
            feed(16'b011, 3);
            if (i == 1) begin chk("t5_cnt3", cntb, 3); chk("t5_nosat", satb, 0); end
            if (i == 2) chk("t5_sat4", satb, 1);
        end
        chk("t5_cnt_hold", cntb, 3);
        chk("t5_sat", satb, 1);
        chk("t5_cnt8", cnta, 5);
        step(0, 0, 1, zs);
        chk("t5_clr_cnt", cntb, 0);
        chk("t5_clr_sat", satb, 0);

        // clr together with the completing bit
        feed(16'b101, 3);
        step(1, 1, 1, zs);
        chk("t6_z", zs, 1);
        chk("t6_cnt", cnta, 0);
        chk("t6_state", {q1a, q0a}, 0);
        chk("t6_zq", zqa, 0);
        step(0, 0, 0, zs);

        cmp_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
